// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : uart_pkg
// Purpose  : Shared scheduler FSM encodings and ASCII constants.
// Revision : 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_LF   = 8'd10;
  localparam logic [7:0] ASCII_ZERO = 8'd48;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: first requester at or after ptr.
// Revision : 1.0
// ----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  int            pos;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    cand  = '0;
    // Walk ptr, ptr+1, ... wrapping at NUM_REQ; keep the first hit.
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      cand = IW'(pos);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : uart_tx_scheduler
// Purpose  : Message-granular round-robin sharing of one UART transmitter.
// Revision : 1.0
// ----------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int GUARD_CLKS = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_BYTE,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 TX_DV,
  output logic [7:0]           TX_BYTE,
  input  logic                 TX_DONE
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int GW = (GUARD_CLKS > 0) ? $clog2(GUARD_CLKS + 1) : 1;

  state_t               state,    state_d;
  logic [NUM_REQ-1:0]   grant_q,  grant_d;
  logic [IW-1:0]        idx_q,    idx_d;
  logic [IW-1:0]        rr_ptr,   rr_ptr_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 last_q,   last_d;
  logic [GW-1:0]        guard,    guard_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic [7:0]           sel_byte;
  logic                 sel_last;
  logic                 xfer;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (REQ_VALID),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign REQ_READY = (state == ST_FETCH) ? (grant_q & REQ_VALID) : '0;
  assign xfer      = |REQ_READY;
  assign GRANT     = grant_q;
  assign TX_DV     = (state == ST_SEND);
  assign TX_BYTE   = tx_byte_q;

  always_comb begin
    sel_byte = 8'h00;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_byte = REQ_BYTE[8*i +: 8];
        sel_last = REQ_LAST[i];
      end
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr;
    tx_byte_d = tx_byte_q;
    last_d    = last_q;
    guard_d   = guard;
    case (state)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d = arb_grant;
          idx_d   = arb_idx;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (xfer) begin
          tx_byte_d = sel_byte;
          last_d    = sel_last;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        // TX_DONE only matters here; every other state ignores it.
        if (TX_DONE) begin
          if (!last_q) begin
            state_d = ST_FETCH;
          end else begin
            rr_ptr_d = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
            grant_d  = '0;
            guard_d  = GW'(GUARD_CLKS);
            state_d  = (GUARD_CLKS > 0) ? ST_GUARD : ST_IDLE;
          end
        end
      end
      ST_GUARD: begin
        if (guard <= GW'(1)) begin
          guard_d = '0;
          state_d = ST_IDLE;
        end else begin
          guard_d = guard - GW'(1);
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      idx_q     <= '0;
      rr_ptr    <= '0;
      tx_byte_q <= 8'h00;
      last_q    <= 1'b0;
      guard     <= '0;
    end else begin
      state     <= state_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      rr_ptr    <= rr_ptr_d;
      tx_byte_q <= tx_byte_d;
      last_q    <= last_d;
      guard     <= guard_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_uart_tx_scheduler
// Purpose  : Directed self-checking bench for uart_tx_scheduler.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (no guard)
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_byte;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   grant;
  logic           tx_dv;
  logic [7:0]     tx_byte;
  logic           tx_done;
  logic           spur;

  // Guard instance
  logic           g_rst;
  logic [N-1:0]   g_valid;
  logic [8*N-1:0] g_byte;
  logic [N-1:0]   g_last;
  logic [N-1:0]   g_ready;
  logic [N-1:0]   g_grant;
  logic           g_dv;
  logic [7:0]     g_txb;
  logic           g_done;

  uart_tx_scheduler #(.NUM_REQ(N), .GUARD_CLKS(0)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_BYTE(req_byte),
    .REQ_LAST(req_last), .REQ_READY(req_ready), .GRANT(grant),
    .TX_DV(tx_dv), .TX_BYTE(tx_byte), .TX_DONE(tx_done)
  );

  uart_tx_scheduler #(.NUM_REQ(N), .GUARD_CLKS(3)) dut_g (
    .CLK(clk), .RST(g_rst), .REQ_VALID(g_valid), .REQ_BYTE(g_byte),
    .REQ_LAST(g_last), .REQ_READY(g_ready), .GRANT(g_grant),
    .TX_DV(g_dv), .TX_BYTE(g_txb), .TX_DONE(g_done)
  );

  // uart_tx2 stand-ins: TX_DONE pulses 5 clocks after TX_DV, unaffected by RST
  int cnt = 0;
  int cnt_g = 0;
  always @(posedge clk) begin
    if (tx_dv) cnt <= 5; else if (cnt != 0) cnt <= cnt - 1;
    if (g_dv) cnt_g <= 5; else if (cnt_g != 0) cnt_g <= cnt_g - 1;
  end
  assign tx_done = (cnt == 1) | spur;
  assign g_done  = (cnt_g == 1);

  logic [7:0]   log_byte[$];
  logic [N-1:0] log_grant[$];
  int dv_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  always @(negedge clk) begin
    if (tx_dv === 1'b1) begin
      log_byte.push_back(tx_byte);
      log_grant.push_back(grant);
      dv_cnt++;
    end
    if (tx_done === 1'b1) done_cnt++;
    if ($countones(req_ready) > 1 || (req_ready & ~grant) != '0) viol++;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dv(input string tag);
    int t;
    t = 0;
    while (tx_dv !== 1'b1 && t < 100) begin tick(); t++; end
    chk({tag, "_dv_seen"}, 32'(tx_dv), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (grant !== '0 && t < 100) begin tick(); t++; end
    chk({tag, "_released"}, 32'(grant), 32'd0);
  endtask

  task automatic wait_state(input string tag, input state_t s);
    int t;
    t = 0;
    while (dut.state !== s && t < 100) begin tick(); t++; end
    chk({tag, "_state"}, 32'(dut.state), 32'(s));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // All requesters in mask send nmsg 2-byte messages, byte = {r, msg, pos}
  task automatic run_prod(input logic [N-1:0] mask, input int nmsg);
    int pos[N];
    int msg[N];
    logic [N-1:0] xf;
    int t;
    bit busy;
    for (int r = 0; r < N; r++) begin pos[r] = 0; msg[r] = 0; end
    t = 0;
    busy = 1'b1;
    while (busy && t < 2000) begin
      busy = 1'b0;
      for (int r = 0; r < N; r++) begin
        req_valid[r]       = mask[r] && (msg[r] < nmsg);
        req_byte[8*r +: 8] = 8'(r * 16 + msg[r] * 2 + pos[r]);
        req_last[r]        = (pos[r] == 1);
        if (req_valid[r]) busy = 1'b1;
      end
      #1;
      xf = req_ready & req_valid;
      tick();
      t++;
      for (int r = 0; r < N; r++) begin
        if (xf[r]) begin
          if (pos[r] == 1) begin pos[r] = 0; msg[r]++; end
          else pos[r] = 1;
        end
      end
    end
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t, gc, d;
    bit gbad;
    rst = 1'b1; g_rst = 1'b1; spur = 1'b0;
    req_valid = '0; req_byte = '0; req_last = '0;
    g_valid = '0; g_byte = '0; g_last = '0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_grant",   32'(grant),     32'd0);
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_dv",      32'(tx_dv),     32'd0);
    chk("rst_txbyte",  32'(tx_byte),   32'd0);
    chk("rst_rrptr",   32'(dut.rr_ptr), 32'd0);
    chk("rst_state",   32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    tick();

    // 1: requester 0 sends "AB"
    req_valid = 4'b0001; req_byte[7:0] = 8'h41; req_last = '0;
    tick();
    chk("t1_grant",      32'(grant),     32'h1);
    chk("t1_ready_lat",  32'(req_ready), 32'h1);
    tick();
    chk("t1_dv_a",       32'(tx_dv),     32'd1);
    chk("t1_byte_a",     32'(tx_byte),   32'h41);
    req_byte[7:0] = 8'h42; req_last = 4'b0001;
    tick();
    chk("t1_dv_onecyc",  32'(tx_dv),     32'd0);
    chk("t1_ready_send", 32'(req_ready), 32'd0);
    wait_dv("t1_b");
    chk("t1_byte_b",     32'(tx_byte),   32'h42);
    chk("t1_grant_b",    32'(grant),     32'h1);
    req_valid = '0; req_last = '0;
    wait_idle("t1");
    chk("t1_rrptr",      32'(dut.rr_ptr), 32'd1);
    chk("t1_dvcount",    32'(dv_cnt),    32'd2);
    chk("t1_idle",       32'(dut.state), 32'(ST_IDLE));

    // 2: all four requesting, two 2-byte messages each
    do_reset();
    log_byte.delete(); log_grant.delete();
    run_prod(4'b1111, 2);
    wait_idle("t2");
    chk("t2_logsize", 32'(log_byte.size()), 32'd16);
    if (log_byte.size() == 16) begin
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("t2_grant_%0d", k), 32'(log_grant[k]), 32'(1 << ((k % 8) / 2)));
        chk($sformatf("t2_byte_%0d", k),  32'(log_byte[k]),
            32'(((k % 8) / 2) * 16 + (k / 8) * 2 + (k % 2)));
      end
    end
    chk("t2_ready_excl", 32'(viol), 32'd0);

    // 3: requester 2 withdraws VALID mid-message for 20 clocks
    do_reset();
    req_valid = 4'b0100; req_byte[23:16] = 8'hC0; req_last = '0;
    wait_dv("t3_b0");
    chk("t3_byte0", 32'(tx_byte), 32'hC0);
    chk("t3_grant0", 32'(grant), 32'h4);
    req_byte[23:16] = 8'hC1;
    tick();
    wait_dv("t3_b1");
    chk("t3_byte1", 32'(tx_byte), 32'hC1);
    req_valid = '0;
    d = dv_cnt;
    repeat (20) tick();
    chk("t3_gap_grant", 32'(grant), 32'h4);
    chk("t3_gap_nodv",  32'(dv_cnt), 32'(d));
    chk("t3_gap_state", 32'(dut.state), 32'(ST_FETCH));
    req_valid = 4'b0100; req_byte[23:16] = 8'hC2; req_last = 4'b0100;
    wait_dv("t3_b2");
    chk("t3_byte2", 32'(tx_byte), 32'hC2);
    chk("t3_grant2", 32'(grant), 32'h4);
    req_valid = '0; req_last = '0;
    wait_idle("t3");
    chk("t3_rrptr", 32'(dut.rr_ptr), 32'd3);

    // 4: spurious TX_DONE in IDLE and FETCH
    spur = 1'b1; tick(); spur = 1'b0; tick();
    chk("t4_idle_state", 32'(dut.state), 32'(ST_IDLE));
    chk("t4_idle_grant", 32'(grant), 32'd0);
    chk("t4_idle_byte",  32'(tx_byte), 32'hC2);
    req_valid = 4'b0001; req_byte[7:0] = 8'h55; req_last = '0;
    wait_dv("t4_b0");
    chk("t4_byte0", 32'(tx_byte), 32'h55);
    req_valid = '0;
    wait_state("t4_fetch", ST_FETCH);
    spur = 1'b1; tick(); spur = 1'b0; tick();
    chk("t4_fetch_state", 32'(dut.state), 32'(ST_FETCH));
    chk("t4_fetch_byte",  32'(tx_byte), 32'h55);
    chk("t4_fetch_grant", 32'(grant), 32'h1);
    chk("t4_fetch_nodv",  32'(tx_dv), 32'd0);
    req_valid = 4'b0001; req_byte[7:0] = 8'h56; req_last = 4'b0001;
    wait_dv("t4_b1");
    chk("t4_byte1", 32'(tx_byte), 32'h56);
    req_valid = '0; req_last = '0;
    wait_idle("t4");

    // 5: reset in WAIT during requester 1's message
    do_reset();
    req_valid = 4'b0010; req_byte[15:8] = 8'h31; req_last = '0;
    wait_dv("t5_b0");
    chk("t5_grant0", 32'(grant), 32'h2);
    tick();
    chk("t5_in_wait", 32'(dut.state), 32'(ST_WAIT));
    rst = 1'b1; req_valid = '0;
    tick();
    chk("t5_rst_grant", 32'(grant), 32'd0);
    chk("t5_rst_dv",    32'(tx_dv), 32'd0);
    chk("t5_rst_rrptr", 32'(dut.rr_ptr), 32'd0);
    chk("t5_rst_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    d = done_cnt;
    repeat (8) tick();
    chk("t5_stale_done", 32'(done_cnt), 32'(d + 1));
    chk("t5_stale_state", 32'(dut.state), 32'(ST_IDLE));
    chk("t5_stale_grant", 32'(grant), 32'd0);
    req_valid = 4'b0011; req_byte[7:0] = ASCII_ZERO; req_byte[15:8] = ASCII_LF;
    req_last = 4'b0011;
    wait_dv("t5_r0");
    chk("t5_first_grant", 32'(grant), 32'h1);
    chk("t5_first_byte",  32'(tx_byte), 32'(ASCII_ZERO));
    req_valid = 4'b0010;
    tick();
    wait_dv("t5_r1");
    chk("t5_second_grant", 32'(grant), 32'h2);
    chk("t5_second_byte",  32'(tx_byte), 32'(ASCII_LF));
    req_valid = '0; req_last = '0;
    wait_idle("t5");

    // 6: GUARD_CLKS=3, back-to-back 1-byte messages from requesters 0 and 1
    g_rst = 1'b0;
    g_valid = 4'b0011; g_byte[7:0] = 8'h61; g_byte[15:8] = 8'h62; g_last = 4'b0011;
    t = 0;
    while (g_dv !== 1'b1 && t < 100) begin tick(); t++; end
    chk("t6_dv0", 32'(g_dv), 32'd1);
    chk("t6_grant0", 32'(g_grant), 32'h1);
    chk("t6_byte0", 32'(g_txb), 32'h61);
    g_valid = 4'b0010;
    t = 0;
    while (dut_g.state !== ST_GUARD && t < 100) begin tick(); t++; end
    chk("t6_enter_guard", 32'(dut_g.state), 32'(ST_GUARD));
    gc = 0; gbad = 1'b0;
    while (dut_g.state === ST_GUARD && gc < 10) begin
      if (g_grant !== '0) gbad = 1'b1;
      gc++;
      tick();
    end
    chk("t6_guard_cycles", 32'(gc), 32'd3);
    chk("t6_guard_nogrant", 32'(gbad), 32'd0);
    chk("t6_after_guard", 32'(dut_g.state), 32'(ST_IDLE));
    tick();
    chk("t6_grant1", 32'(g_grant), 32'h2);
    t = 0;
    while (g_dv !== 1'b1 && t < 100) begin tick(); t++; end
    chk("t6_byte1", 32'(g_txb), 32'h62);
    g_valid = '0;

    chk("final_ready_excl", 32'(viol), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
